// File: rtl/koopa_sprite_addr_gen_if.sv
// Raster-side bundle for the Koopa sprite address stage.
// The raster/control side drives coordinates, tick and sprite attributes.
// The address generator returns the ROM address and the aligned hit flags.
interface koopa_sprite_addr_gen_if;

    logic [9:0]  hcount;
    logic [9:0]  vcount;
    logic        frame_tick;
    logic [9:0]  pos_x;
    logic [9:0]  pos_y;
    logic        face_left;
    logic [1:0]  anim_sel;
    logic [12:0] rom_addr;
    logic        in_sprite;
    logic        in_sprite_rgb;
    logic [2:0]  cur_frame;

    modport master (
        output hcount, vcount, frame_tick, pos_x, pos_y, face_left, anim_sel,
        input  rom_addr, in_sprite, in_sprite_rgb, cur_frame
    );

    modport slave (
        input  hcount, vcount, frame_tick, pos_x, pos_y, face_left, anim_sel,
        output rom_addr, in_sprite, in_sprite_rgb, cur_frame
    );

endinterface

// File: rtl/koopa_sprite_addr_gen.sv
// Koopa sprite ROM address stage.
// It runs the idle/walk/shell animation FSM and hit-tests the raster pixel
// against the sprite box latched at frame_tick.
// It emits the sprite-sheet address one cycle after the pixel.
// It emits a second, delayed hit flag that lines up with the ROM colour output.
module koopa_sprite_addr_gen #(
    parameter int unsigned SPR_W       = 23,
    parameter int unsigned SPR_H       = 30,
    parameter int unsigned FRAME_WORDS = SPR_W * SPR_H,
    parameter int unsigned WALK_DIV    = 8,
    parameter int unsigned SHELL_DIV   = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    koopa_sprite_addr_gen_if.slave  bus
);

    localparam int unsigned CW      = 11;
    localparam int unsigned AW      = 13;
    localparam int unsigned COL_W   = $clog2(SPR_W);
    localparam int unsigned ROW_W   = $clog2(SPR_H);
    localparam int unsigned DIV_MAX = (WALK_DIV > SHELL_DIV) ? WALK_DIV : SHELL_DIV;
    localparam int unsigned DIV_W   = (DIV_MAX > 1) ? $clog2(DIV_MAX) : 1;

    localparam logic [31:0] SPR_W_VEC = 32'(SPR_W);

    localparam logic [2:0] WALK_FIRST  = 3'd0;
    localparam logic [2:0] WALK_LAST   = 3'd3;
    localparam logic [2:0] SHELL_FIRST = 3'd4;
    localparam logic [2:0] SHELL_LAST  = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WALK  = 2'd1,
        ST_SHELL = 2'd2
    } state_t;

    state_t           state_q, state_nxt, req_state;
    logic [2:0]       frame_q, frame_nxt;
    logic [DIV_W-1:0] div_q, div_nxt;

    logic [9:0]       px_q, py_q;
    logic             face_q;

    logic [CW-1:0]    h_ext, v_ext, px_ext, py_ext;
    logic             hit_c;
    logic [COL_W-1:0] col_raw, col;
    logic [ROW_W-1:0] row;
    logic [AW-1:0]    row_scaled;
    logic [AW-1:0]    addr_c;

    logic [AW-1:0]    rom_addr_q;
    logic             in_sprite_q;
    logic             in_sprite_rgb_q;

    // Constant start address of each sheet frame
    function automatic logic [AW-1:0] frame_base(input logic [2:0] f);
        case (f)
            3'd0:    frame_base = AW'(0);
            3'd1:    frame_base = AW'(FRAME_WORDS);
            3'd2:    frame_base = AW'(2 * FRAME_WORDS);
            3'd3:    frame_base = AW'(3 * FRAME_WORDS);
            3'd4:    frame_base = AW'(4 * FRAME_WORDS);
            3'd5:    frame_base = AW'(5 * FRAME_WORDS);
            default: frame_base = AW'(0);
        endcase
    endfunction

    // Sprite attributes are captured only at frame_tick so a frame never tears
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            px_q   <= '0;
            py_q   <= '0;
            face_q <= 1'b0;
        end else if (bus.frame_tick) begin
            px_q   <= bus.pos_x;
            py_q   <= bus.pos_y;
            face_q <= bus.face_left;
        end
    end

    // Animation state, frame index and tick divider
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            frame_q <= '0;
            div_q   <= '0;
        end else begin
            state_q <= state_nxt;
            frame_q <= frame_nxt;
            div_q   <= div_nxt;
        end
    end

    // Next animation state: a mode change restarts the sequence, otherwise divide ticks
    always_comb begin
        state_nxt = state_q;
        frame_nxt = frame_q;
        div_nxt   = div_q;
        req_state = ST_IDLE;

        case (bus.anim_sel)
            2'b01:   req_state = ST_WALK;
            2'b10:   req_state = ST_SHELL;
            default: req_state = ST_IDLE;
        endcase

        if (bus.frame_tick) begin
            if (req_state != state_q) begin
                state_nxt = req_state;
                frame_nxt = (req_state == ST_SHELL) ? SHELL_FIRST : WALK_FIRST;
                div_nxt   = '0;
            end else begin
                case (state_q)
                    ST_WALK: begin
                        if (div_q == DIV_W'(WALK_DIV - 1)) begin
                            div_nxt   = '0;
                            frame_nxt = (frame_q == WALK_LAST) ? WALK_FIRST : frame_q + 3'd1;
                        end else begin
                            div_nxt   = div_q + DIV_W'(1);
                        end
                    end
                    ST_SHELL: begin
                        if (div_q == DIV_W'(SHELL_DIV - 1)) begin
                            div_nxt   = '0;
                            frame_nxt = (frame_q == SHELL_LAST) ? SHELL_FIRST : frame_q + 3'd1;
                        end else begin
                            div_nxt   = div_q + DIV_W'(1);
                        end
                    end
                    default: begin
                        frame_nxt = WALK_FIRST;
                        div_nxt   = '0;
                    end
                endcase
            end
        end
    end

    // Box test and sheet address for the current pixel; 11-bit compare avoids edge wrap
    always_comb begin
        h_ext   = {1'b0, bus.hcount};
        v_ext   = {1'b0, bus.vcount};
        px_ext  = {1'b0, px_q};
        py_ext  = {1'b0, py_q};

        hit_c   = (h_ext >= px_ext) && (h_ext < px_ext + CW'(SPR_W)) &&
                  (v_ext >= py_ext) && (v_ext < py_ext + CW'(SPR_H));

        col_raw = COL_W'(h_ext - px_ext);
        col     = face_q ? (COL_W'(SPR_W - 1) - col_raw) : col_raw;
        row     = ROW_W'(v_ext - py_ext);

        // row * SPR_W as a sum of shifted copies of row
        row_scaled = '0;
        for (int i = 0; i <= int'(COL_W); i++) begin
            if (SPR_W_VEC[i]) begin
                row_scaled = row_scaled + (AW'(row) << i);
            end
        end

        addr_c = frame_base(frame_q) + row_scaled + AW'(col);
    end

    // Address/hit register, then one more stage to match the ROM's registered colour
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rom_addr_q      <= '0;
            in_sprite_q     <= 1'b0;
            in_sprite_rgb_q <= 1'b0;
        end else begin
            rom_addr_q      <= hit_c ? addr_c : '0;
            in_sprite_q     <= hit_c;
            in_sprite_rgb_q <= in_sprite_q;
        end
    end

    assign bus.rom_addr      = rom_addr_q;
    assign bus.in_sprite     = in_sprite_q;
    assign bus.in_sprite_rgb = in_sprite_rgb_q;
    assign bus.cur_frame     = frame_q;

endmodule

// File: tb/tb_koopa_sprite_addr_gen.sv
// Directed bench for koopa_sprite_addr_gen: a vector table for the pixel/latch
// behaviour plus hand-written sequences for animation, clipping and reset.
module tb_koopa_sprite_addr_gen;

    logic clk = 1'b0;
    logic rst;

    koopa_sprite_addr_gen_if bus();

    koopa_sprite_addr_gen dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       tick;
        logic       face;
        logic [1:0] anim;
        int         px;
        int         py;
        int         h;
        int         v;
        int         addr;
        int         hit;
        int         frame;
    } vec_t;

    vec_t tbl[13];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic tick(input logic [1:0] a);
        bus.anim_sel   = a;
        bus.frame_tick = 1'b1;
        step();
        bus.frame_tick = 1'b0;
    endtask

    task automatic pixel(input string name, input int h, input int v, input int addr, input int hit);
        bus.hcount = 10'(h);
        bus.vcount = 10'(v);
        step();
        chk({name, "_addr"}, int'(bus.rom_addr), addr);
        chk({name, "_hit"}, int'(bus.in_sprite), hit);
    endtask

    initial begin
        int prev_hit;

        //         tick  face anim   px   py   h    v    addr hit frame
        tbl[0]  = '{1'b0, 1'b0, 2'b00, 100, 50,   5,   2,  51, 1, 0};
        tbl[1]  = '{1'b1, 1'b0, 2'b00, 100, 50,   0,   0,   0, 1, 0};
        tbl[2]  = '{1'b0, 1'b0, 2'b00, 100, 50, 100,  50,   0, 1, 0};
        tbl[3]  = '{1'b0, 1'b0, 2'b00, 100, 50, 122,  79, 689, 1, 0};
        tbl[4]  = '{1'b0, 1'b0, 2'b00, 100, 50, 123,  79,   0, 0, 0};
        tbl[5]  = '{1'b0, 1'b0, 2'b00, 100, 50,  99,  50,   0, 0, 0};
        tbl[6]  = '{1'b0, 1'b0, 2'b00, 100, 50, 100,  80,   0, 0, 0};
        tbl[7]  = '{1'b0, 1'b0, 2'b00, 100, 50, 110,  60, 240, 1, 0};
        tbl[8]  = '{1'b1, 1'b1, 2'b00, 100, 50, 100,  50,   0, 1, 0};
        tbl[9]  = '{1'b0, 1'b1, 2'b00, 100, 50, 100,  50,  22, 1, 0};
        tbl[10] = '{1'b0, 1'b1, 2'b00, 100, 50, 122,  51,  23, 1, 0};
        tbl[11] = '{1'b0, 1'b1, 2'b00, 100, 50, 111,  50,  11, 1, 0};
        tbl[12] = '{1'b0, 1'b0, 2'b01,   0,  0, 100,  50,  22, 1, 0};

        rst            = 1'b1;
        bus.hcount     = '0;
        bus.vcount     = '0;
        bus.frame_tick = 1'b0;
        bus.pos_x      = '0;
        bus.pos_y      = '0;
        bus.face_left  = 1'b0;
        bus.anim_sel   = 2'b00;
        step();
        step();
        chk("reset_addr", int'(bus.rom_addr), 0);
        chk("reset_hit", int'(bus.in_sprite), 0);
        chk("reset_rgb", int'(bus.in_sprite_rgb), 0);
        chk("reset_frame", int'(bus.cur_frame), 0);
        rst = 1'b0;

        // Vector table: one cycle per record, colour flag checked against the previous record
        prev_hit = 0;
        for (int i = 0; i < 13; i++) begin
            bus.frame_tick = tbl[i].tick;
            bus.face_left  = tbl[i].face;
            bus.anim_sel   = tbl[i].anim;
            bus.pos_x      = 10'(tbl[i].px);
            bus.pos_y      = 10'(tbl[i].py);
            bus.hcount     = 10'(tbl[i].h);
            bus.vcount     = 10'(tbl[i].v);
            step();
            chk($sformatf("vec%0d_addr", i), int'(bus.rom_addr), tbl[i].addr);
            chk($sformatf("vec%0d_hit", i), int'(bus.in_sprite), tbl[i].hit);
            chk($sformatf("vec%0d_rgb", i), int'(bus.in_sprite_rgb), prev_hit);
            chk($sformatf("vec%0d_frame", i), int'(bus.cur_frame), tbl[i].frame);
            prev_hit = tbl[i].hit;
        end
        bus.frame_tick = 1'b0;

        // Walk cycle: 8 ticks per frame through 0..3 and back to 0
        bus.pos_x     = 10'd100;
        bus.pos_y     = 10'd50;
        bus.face_left = 1'b0;
        bus.hcount    = '0;
        bus.vcount    = '0;
        tick(2'b01);
        chk("walk_enter", int'(bus.cur_frame), 0);
        for (int k = 1; k <= 32; k++) begin
            tick(2'b01);
            chk($sformatf("walk_tick%0d", k), int'(bus.cur_frame), (k / 8) % 4);
        end
        for (int k = 0; k < 16; k++) tick(2'b01);
        chk("walk_frame2", int'(bus.cur_frame), 2);
        pixel("walk_px", 105, 52, 1431, 1);
        bus.hcount = '0;
        bus.vcount = '0;

        // Shell entry mid-walk (frame 2, divider 5), then 3 ticks per frame over 4..5
        for (int k = 0; k < 5; k++) tick(2'b01);
        chk("walk_div5_frame", int'(bus.cur_frame), 2);
        tick(2'b10);
        chk("shell_enter", int'(bus.cur_frame), 4);
        for (int j = 1; j <= 9; j++) begin
            tick(2'b10);
            chk($sformatf("shell_tick%0d", j), int'(bus.cur_frame), ((j / 3) % 2 == 1) ? 5 : 4);
        end
        pixel("shell_last", 122, 79, 4139, 1);

        // Right/bottom clipping and 11-bit box end near x=1023
        bus.pos_x  = 10'd630;
        bus.pos_y  = 10'd470;
        bus.hcount = '0;
        bus.vcount = '0;
        tick(2'b00);
        chk("clip_idle_frame", int'(bus.cur_frame), 0);
        pixel("clip_639", 639, 470, 9, 1);
        pixel("clip_wrap", 0, 471, 0, 0);
        pixel("clip_left", 629, 470, 0, 0);
        bus.pos_x  = 10'd1020;
        bus.pos_y  = 10'd0;
        bus.hcount = '0;
        bus.vcount = 10'd500;
        tick(2'b00);
        pixel("edge_1023", 1023, 0, 3, 1);
        pixel("edge_1019", 1019, 0, 0, 0);

        // Asynchronous reset in frame 3 of a walk
        bus.pos_x  = 10'd100;
        bus.pos_y  = 10'd50;
        bus.hcount = '0;
        bus.vcount = '0;
        tick(2'b01);
        for (int k = 0; k < 24; k++) tick(2'b01);
        chk("pre_rst_frame", int'(bus.cur_frame), 3);
        pixel("pre_rst_px", 110, 60, 2310, 1);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_addr", int'(bus.rom_addr), 0);
        chk("async_rst_hit", int'(bus.in_sprite), 0);
        chk("async_rst_rgb", int'(bus.in_sprite_rgb), 0);
        chk("async_rst_frame", int'(bus.cur_frame), 0);
        #1 rst = 1'b0;
        step();
        chk("post_rst_hit", int'(bus.in_sprite), 0);
        chk("post_rst_frame", int'(bus.cur_frame), 0);
        tick(2'b01);
        for (int k = 0; k < 7; k++) tick(2'b01);
        chk("resume_walk_7", int'(bus.cur_frame), 0);
        tick(2'b01);
        chk("resume_walk_8", int'(bus.cur_frame), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
